// File: rtl/fetch_cycle_pkg.sv
// fetch_cycle_pkg: shared state encoding and constants for the fetch stage
package fetch_cycle_pkg;
  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;
  localparam logic [15:0] NOP = 16'h0000;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
endpackage

// File: rtl/fetch_cycle.sv
// fetch_cycle: instruction-fetch stage, one outstanding imem request, ir/pcout with valid
module fetch_cycle
  import fetch_cycle_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] ir,
  output logic [15:0] pcout,
  output logic        irvalid
);
  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_fpc;
  logic [15:0] r_hold;
  logic [15:0] r_ir;
  logic [15:0] r_pcout;
  logic        r_irvalid;
  logic        w_slot_free;
  assign w_slot_free = !r_irvalid || !stall;
  assign imem_req    = (r_state == ISSUE) && !redirect;
  assign imem_addr   = r_pc;
  assign ir          = r_ir;
  assign pcout       = r_pcout;
  assign irvalid     = r_irvalid;
  // r_fpc tags the in-flight word; it also tags the hold register since no new request issues in HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ISSUE;
      r_pc      <= RESET_PC;
      r_fpc     <= RESET_PC;
      r_hold    <= NOP;
      r_ir      <= NOP;
      r_pcout   <= 16'h0000;
      r_irvalid <= 1'b0;
    end else if (redirect) begin
      r_pc      <= target;
      r_ir      <= NOP;
      r_irvalid <= 1'b0;
      r_hold    <= NOP;
      r_state   <= ((r_state == WAIT && !imem_rvalid) || r_state == DROP) ? DROP : ISSUE;
    end else begin
      if (r_irvalid && !stall) r_irvalid <= 1'b0;
      case (r_state)
        ISSUE: if (imem_ready) begin
          r_fpc   <= r_pc;
          r_pc    <= r_pc + PC_STEP;
          r_state <= WAIT;
        end
        WAIT: if (imem_rvalid) begin
          if (w_slot_free) begin
            r_ir      <= imem_rdata;
            r_pcout   <= r_fpc;
            r_irvalid <= 1'b1;
            r_state   <= ISSUE;
          end else begin
            r_hold  <= imem_rdata;
            r_state <= HOLD;
          end
        end
        HOLD: if (w_slot_free) begin
          r_ir      <= r_hold;
          r_pcout   <= r_fpc;
          r_irvalid <= 1'b1;
          r_state   <= ISSUE;
        end
        DROP: if (imem_rvalid) r_state <= ISSUE;
        default: r_state <= ISSUE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_cycle.sv
// tb_fetch_cycle: directed vector table, hand sequences and random run against a fetch scoreboard
module tb_fetch_cycle;
  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_ready, imem_rvalid;
  logic [15:0] target, imem_rdata;
  logic        imem_req, irvalid;
  logic [15:0] imem_addr, ir, pcout;
  int          total = 0;
  int          bad = 0;
  int          consumed = 0;
  int          resp_cnt = -1;
  int          lat = 1;
  logic [15:0] resp_addr = 16'h0000;
  logic        poison = 1'b0;
  logic        dead_seen = 1'b0;
  logic [31:0] sb[$];
  typedef struct {
    logic        stall;
    logic        ready;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_irv;
    logic [15:0] exp_ir;
    logic [15:0] exp_pc;
  } vec_t;
  vec_t tbl[18];
  fetch_cycle dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .target(target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ir(ir), .pcout(pcout), .irvalid(irvalid)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] mem(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0002) return 16'h5678;
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic settle();
    if (rst) resp_cnt = -1;
    if (resp_cnt > 0) resp_cnt--;
    imem_rvalid = !rst && resp_cnt == 0;
    imem_rdata  = !imem_rvalid ? 16'h0000 : poison ? 16'hDEAD : mem(resp_addr);
    #1;
    if (irvalid && ir == 16'hDEAD) dead_seen = 1'b1;
  endtask
  task automatic advance();
    logic [31:0] e;
    if (rst) begin
      sb.delete();
      resp_cnt = -1;
      poison = 1'b0;
    end else begin
      if (redirect) sb.delete();
      else if (irvalid && !stall) begin
        consumed++;
        if (sb.size() == 0) chk("sb_empty", 16'h0001, 16'h0000);
        else begin
          e = sb.pop_front();
          chk("sb_ir", ir, e[15:0]);
          chk("sb_pcout", pcout, e[31:16]);
        end
      end
      if (imem_req && imem_ready) begin
        sb.push_back({imem_addr, mem(imem_addr)});
        resp_addr = imem_addr;
        resp_cnt = lat;
      end else if (imem_rvalid) begin
        resp_cnt = -1;
        poison = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic tick();
    settle();
    advance();
  endtask
  task automatic chk_out(input string name, input logic req, input logic [15:0] addr,
                         input logic irv, input logic [15:0] exp_ir);
    chk({name, "_req"}, {15'd0, imem_req}, {15'd0, req});
    chk({name, "_addr"}, imem_addr, addr);
    chk({name, "_irv"}, {15'd0, irvalid}, {15'd0, irv});
    chk({name, "_ir"}, ir, exp_ir);
  endtask
  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'h0002, 1'b0, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h1234, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h0004, 1'b0, 16'h1234, 16'h0000};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'h0004, 1'b1, 16'h5678, 16'h0002};
    for (int i = 5; i < 9; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h5678, 16'h0002};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 16'h5678, 16'h0002};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h0006, 1'b0, 16'h5678, 16'h0002};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 16'h0006, 1'b1, 16'hC7A5, 16'h0004};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h0008, 1'b0, 16'hC7A5, 16'h0004};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 16'h0008, 1'b1, 16'hC5A5, 16'h0006};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 16'h000A, 1'b1, 16'hC5A5, 16'h0006};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 16'h000A, 1'b1, 16'hC5A5, 16'h0006};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 16'h000A, 1'b1, 16'hC5A5, 16'h0006};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 16'h000A, 1'b1, 16'hCBA5, 16'h0008};
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; target = 16'h0000; imem_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 16'h0000;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    // basic fetch, ready held low, stall with hold register
    for (int i = 0; i < 18; i++) begin
      stall = tbl[i].stall;
      imem_ready = tbl[i].ready;
      settle();
      chk_out($sformatf("vec%0d", i), tbl[i].exp_req, tbl[i].exp_addr, tbl[i].exp_irv, tbl[i].exp_ir);
      chk($sformatf("vec%0d_pcout", i), pcout, tbl[i].exp_pc);
      advance();
    end
    // redirect while waiting; late response must be dropped
    tick();
    lat = 3; poison = 1'b1;
    settle(); chk_out("pre_redir", 1'b1, 16'h000C, 1'b1, 16'hC9A5); advance();
    redirect = 1'b1; target = 16'h0040;
    settle(); chk("redir_req", {15'd0, imem_req}, 16'h0000); advance();
    redirect = 1'b0;
    settle(); chk_out("drop1", 1'b0, 16'h0040, 1'b0, 16'h0000); advance();
    settle(); chk("drop_late_rvalid", {15'd0, imem_rvalid}, 16'h0001);
    chk("drop2_req", {15'd0, imem_req}, 16'h0000); advance();
    lat = 1;
    settle(); chk_out("refetch", 1'b1, 16'h0040, 1'b0, 16'h0000); advance();
    tick();
    stall = 1'b1;
    settle(); chk_out("tgt_word", 1'b1, 16'h0042, 1'b1, 16'h83A5); chk("tgt_pc", pcout, 16'h0040); advance();
    // redirect under stall in the same cycle as a response
    redirect = 1'b1; target = 16'h0080;
    settle(); chk("rv_redir_rvalid", {15'd0, imem_rvalid}, 16'h0001); advance();
    redirect = 1'b0; stall = 1'b0;
    settle(); chk_out("flush", 1'b1, 16'h0080, 1'b0, 16'h0000); advance();
    tick();
    settle(); chk("t80_ir", ir, 16'h43A5); chk("t80_pc", pcout, 16'h0080);
    // redirect from ISSUE suppresses the request; then PC wraps
    redirect = 1'b1; target = 16'hFFFE;
    #0; chk("issue_redir_req", {15'd0, imem_req}, 16'h0000); advance();
    redirect = 1'b0;
    settle(); chk_out("wrap_issue", 1'b1, 16'hFFFE, 1'b0, 16'h0000); advance();
    settle(); chk("wrap_addr", imem_addr, 16'h0000); advance();
    settle(); chk_out("wrap_word", 1'b1, 16'h0000, 1'b1, 16'h3D5A); chk("wrap_pc", pcout, 16'hFFFE);
    // reset while waiting
    lat = 2; advance();
    rst = 1'b1; tick(); rst = 1'b0;
    settle(); chk_out("rst_wait", 1'b1, 16'h0000, 1'b0, 16'h0000);
    lat = 1; advance();
    tick();
    stall = 1'b1; tick(); tick();
    settle(); chk_out("in_hold", 1'b0, 16'h0004, 1'b1, 16'h1234); advance();
    rst = 1'b1; tick(); rst = 1'b0; stall = 1'b0;
    settle(); chk_out("rst_hold", 1'b1, 16'h0000, 1'b0, 16'h0000); advance();
    // random traffic checked only by the scoreboard
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 2) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      target = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE;
      lat = $urandom_range(1, 3);
      tick();
    end
    redirect = 1'b0; stall = 1'b0;
    chk("no_dead", {15'd0, dead_seen}, 16'h0000);
    chk("consumed_any", {15'd0, consumed > 20}, 16'h0001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_cycle.md
Name: fetch_cycle

Overview:
- Instruction-fetch stage of the 16-bit pipeline; producer side of the ir/pc interface the decode stage consumes.
- Owns the PC and issues one request at a time to instruction memory over a request/response handshake.
- Presents ir/pcout with a valid flag, holds them under stall, and discards wrong-path fetches on branch redirect.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
PC_STEP, 2, PC increment per sequential fetch (byte-addressed 16-bit instructions)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
stall  input  1  decode not accepting; output registers hold
redirect  input  1  branch/jump taken; flush and refetch at target
target  input  16  redirect destination PC
imem_req  output  1  request valid to instruction memory
imem_addr  output  16  request address
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  16  response instruction word
ir  output  16  fetched instruction to decode
pcout  output  16  PC of ir
irvalid  output  1  ir/pcout hold a live instruction

Behaviour:
- Reset (rst=1 at posedge): pc=RESET_PC, state=ISSUE, ir=16'h0000, pcout=16'h0000, irvalid=0, hold register cleared. rst overrides every other input.
- imem_req = (state==ISSUE) && !redirect. imem_addr = pc (combinational).
- Request handshake: the request is accepted when imem_req && imem_ready. At most one request is outstanding. The response arrives at least one cycle after acceptance.
- State machine (2-bit state; states ISSUE, WAIT, HOLD, DROP):
  - ISSUE, on accept: fpc<=pc, pc<=pc+PC_STEP (16-bit wrap, 16'hFFFE+2=16'h0000), go to WAIT.
  - WAIT, on imem_rvalid with slot free: load ir<=imem_rdata, pcout<=fpc, irvalid<=1, go to ISSUE.
  - WAIT, on imem_rvalid with slot busy: store the data in the hold register and go to HOLD.
  - HOLD, when the slot frees: move hold to the output and go to ISSUE.
  - DROP, on imem_rvalid: discard the data and go to ISSUE.
- Slot free: !irvalid || !stall.
- Output register when no new data arrives: if irvalid && !stall, decode consumes the instruction and irvalid<=0. If stall=1, ir/pcout/irvalid hold unchanged.
- Redirect (highest priority after rst):
  - pc<=target.
  - Output flushed: irvalid<=0, ir<=16'h0000.
  - Hold register discarded.
  - From ISSUE: stay in ISSUE; no request is issued that cycle.
  - From WAIT without rvalid: go to DROP.
  - From WAIT with rvalid the same cycle: drop the data, go to ISSUE.
  - From HOLD: go to ISSUE.
  - From DROP: stay in DROP; pc is updated to the new target.
- Redirect with stall=1: redirect wins, and the output is flushed regardless of stall.
- Throughput: one instruction every 2 cycles with single-cycle memory. Back-to-back pipelining of requests is out of scope.
- Wrong-path data never reaches ir.
- pcout always equals the address the word in ir was fetched from.

Decomposition:
- Shared package holds:
  - the state encoding constants (ISSUE=2'd0, WAIT=2'd1, HOLD=2'd2, DROP=2'd3);
  - the NOP encoding 16'h0000;
  - the default RESET_PC.
- No sub-module required; pc register, FSM, hold register and output register fit in one module.
- Optional sub-module: pc_reg_component (load/increment/reset), matching the existing *_component style.

Test Plan:
- Reset then imem_ready=1 with 1-cycle memory returning 16'h1234, 16'h5678 → imem_addr 0x0000 then 0x0002. ir=0x1234 with pcout=0x0000, then ir=0x5678 with pcout=0x0002. irvalid pulses once per instruction.
- stall=1 for 3 cycles while a response arrives → first instruction held on ir with irvalid=1. Second word captured in HOLD and no new request issued. It appears on ir the cycle after stall drops.
- redirect=1, target=0x0040, asserted while in WAIT; late response 0xDEAD arrives 2 cycles later → 0xDEAD never appears on ir. Next imem_addr=0x0040 and irvalid=0 until the 0x0040 response arrives.
- redirect and imem_rvalid in the same cycle, plus redirect under stall=1 → data dropped and output flushed (irvalid=0, ir=0x0000). Fetch resumes at target.
- imem_ready held low for 5 cycles → imem_req stays 1 with a stable imem_addr and pc does not advance. Also start from pc=0xFFFE: the next fetch address wraps to 0x0000.
- rst asserted while in WAIT and in HOLD → next cycle: state ISSUE, pc=RESET_PC, irvalid=0. A response arriving after reset is ignored (memory is reset alongside).
